// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample/buffer geometry and the
// transmitter state encoding.
package audio_pkg;

   localparam int DEFAULT_SAMPLE_SIZE  = 24;
   localparam int DEFAULT_IO_BUFF_SIZE = 64;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_PLAY = 1'b1
   } txState_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing generator: BCLK divider, word select and bit counter, plus the
// falling-edge, frame-start and capture strobes used by the transmitter.
module i2s_clk_gen
   import audio_pkg::*;
#(
   parameter int SAMPLE_SIZE = DEFAULT_SAMPLE_SIZE,
   parameter int BCLK_DIV    = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               o_bclk,
   output logic                               o_lrclk,
   output logic [$clog2(2*SAMPLE_SIZE)-1:0]   o_bitNext,
   output logic                               o_fall,
   output logic                               o_frameStart,
   output logic                               o_capture
);

   localparam int CNT_BITS = $clog2(2*SAMPLE_SIZE);
   localparam int DIV_BITS = $clog2(BCLK_DIV);
   localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(BCLK_DIV - 1);
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(2*SAMPLE_SIZE - 1);
   localparam logic [CNT_BITS-1:0] CNT_HALF = CNT_BITS'(SAMPLE_SIZE);

   logic [DIV_BITS-1:0] r_div;
   logic [CNT_BITS-1:0] r_bitCnt;
   logic                r_bclk;
   logic                r_lrclk;
   logic                w_terminal;
   logic                w_fall;
   logic [CNT_BITS-1:0] w_bitNext;

   // Strobes are qualified by the count the bit counter moves to on this F,
   // so "F with bit_cnt = n" is decoded in the same cycle the outputs update.
   assign w_terminal = (r_div == DIV_LAST);
   assign w_fall     = w_terminal & r_bclk;
   assign w_bitNext  = (r_bitCnt == CNT_LAST) ? '0 : r_bitCnt + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div    <= '0;
         r_bclk   <= 1'b0;
      end else begin
         r_div <= w_terminal ? '0 : r_div + 1'b1;
         if (w_terminal)
            r_bclk <= ~r_bclk;
      end
   end

   // Bit counter starts at its last value so the first F after reset opens a left slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bitCnt <= CNT_LAST;
         r_lrclk  <= 1'b1;
      end else if (w_fall) begin
         r_bitCnt <= w_bitNext;
         if (w_bitNext == '0)
            r_lrclk <= 1'b0;
         else if (w_bitNext == CNT_HALF)
            r_lrclk <= 1'b1;
      end
   end

   assign o_bclk       = r_bclk;
   assign o_lrclk      = r_lrclk;
   assign o_bitNext    = w_bitNext;
   assign o_fall       = w_fall;
   assign o_frameStart = w_fall & (w_bitNext == '0);
   assign o_capture    = w_fall & (w_bitNext == CNT_HALF);

endmodule

// File: rtl/i2s_chunk_tx.sv
// Chunked I2S playback: drains the output buffer one sample per frame, sends
// it on both slots, and flags underrun when a chunk boundary finds no new chunk.
module i2s_chunk_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_SIZE      = DEFAULT_SAMPLE_SIZE,
   parameter int IO_BUFF_SIZE     = DEFAULT_IO_BUFF_SIZE,
   parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
   parameter int BCLK_DIV         = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        chunk_pulse,
   output logic [IO_BUFF_PTR_BITS-1:0] output_buff_ptr,
   input  logic [SAMPLE_SIZE-1:0]      output_buff_sample,
   output logic                        i2s_bclk,
   output logic                        i2s_lrclk,
   output logic                        i2s_sdata,
   output logic                        busy,
   output logic                        underrun
);

   localparam int CNT_BITS = $clog2(2*SAMPLE_SIZE);
   localparam int CNT_W    = CNT_BITS + 1;
   localparam int IDX_BITS = $clog2(SAMPLE_SIZE);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2*SAMPLE_SIZE);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE_SIZE);
   localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

   txState_t                    r_state;
   txState_t                    w_stateNext;
   logic                        r_pending;
   logic [IO_BUFF_PTR_BITS-1:0] r_ptr;
   logic [SAMPLE_SIZE-1:0]      r_hold;
   logic [SAMPLE_SIZE-1:0]      r_word;
   logic                        r_sdata;
   logic                        r_underrun;

   logic                        w_fall;
   logic                        w_frameStart;
   logic                        w_capEvt;
   logic [CNT_BITS-1:0]         w_bitNext;
   logic [CNT_W-1:0]            w_bitExt;
   logic [IDX_BITS-1:0]         w_bitIdx;
   logic                        w_pendEff;
   logic                        w_capture;
   logic                        w_zeroHold;
   logic                        w_consume;
   logic                        w_underrun;

   i2s_clk_gen #(
      .SAMPLE_SIZE (SAMPLE_SIZE),
      .BCLK_DIV    (BCLK_DIV)
   ) u_clkGen (
      .clk          (clk),
      .rst          (rst),
      .o_bclk       (i2s_bclk),
      .o_lrclk      (i2s_lrclk),
      .o_bitNext    (w_bitNext),
      .o_fall       (w_fall),
      .o_frameStart (w_frameStart),
      .o_capture    (w_capEvt)
   );

   // A pulse arriving in the same cycle as a consuming capture counts as consumed.
   assign w_pendEff = r_pending | chunk_pulse;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= TX_IDLE;
      else
         r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      w_capture   = 1'b0;
      w_zeroHold  = 1'b0;
      w_consume   = 1'b0;
      w_underrun  = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (w_capEvt) begin
               if (w_pendEff) begin
                  w_capture   = 1'b1;
                  w_consume   = 1'b1;
                  w_stateNext = TX_PLAY;
               end else begin
                  w_zeroHold  = 1'b1;
               end
            end
         end
         TX_PLAY: begin
            if (w_capEvt) begin
               if (r_ptr != '0) begin
                  w_capture   = 1'b1;
               end else if (w_pendEff) begin
                  w_capture   = 1'b1;
                  w_consume   = 1'b1;
               end else begin
                  w_zeroHold  = 1'b1;
                  w_underrun  = 1'b1;
                  w_stateNext = TX_IDLE;
               end
            end
         end
         default: w_stateNext = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending  <= 1'b0;
         r_ptr      <= '0;
         r_hold     <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_underrun;
         if (w_consume)
            r_pending <= 1'b0;
         else if (chunk_pulse)
            r_pending <= 1'b1;
         if (w_capture) begin
            r_hold <= output_buff_sample;
            r_ptr  <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
         end else if (w_zeroHold) begin
            r_hold <= '0;
         end
      end
   end

   // One-bit I2S delay: count n=1..S carries the left slot MSB..LSB, the right
   // slot follows, and its LSB lands on n=0 just as the next word is loaded.
   assign w_bitExt = {1'b0, w_bitNext};

   always_comb begin
      w_bitIdx = '0;
      if (w_bitExt == '0)
         w_bitIdx = '0;
      else if (w_bitExt <= CNT_HALF)
         w_bitIdx = IDX_BITS'(CNT_HALF - w_bitExt);
      else
         w_bitIdx = IDX_BITS'(CNT_FULL - w_bitExt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word  <= '0;
         r_sdata <= 1'b0;
      end else begin
         if (w_frameStart)
            r_word <= r_hold;
         if (w_fall)
            r_sdata <= r_word[w_bitIdx];
      end
   end

   assign output_buff_ptr = r_ptr;
   assign i2s_sdata       = r_sdata;
   assign busy            = (r_state == TX_PLAY);
   assign underrun        = r_underrun;

endmodule
